// File: rtl/dds_sweep_gen_if.sv
// Bus bundle for the DDS sweep generator: shadow-config writes, sweep control, and ramp outputs.
// The master side drives configuration and control; the slave side is the generator.
interface dds_sweep_gen_if #(
    parameter int WIDTH   = 32,
    parameter int NCH     = 3,
    parameter int DWELL_W = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 cfg_wen;
    logic [CHW-1:0]       cfg_ch;
    logic [WIDTH-1:0]     cfg_start;
    logic [WIDTH-1:0]     cfg_end;
    logic [WIDTH-1:0]     cfg_step;
    logic [DWELL_W-1:0]   cfg_dwell;
    logic [1:0]           cfg_mode;
    logic                 restart;
    logic                 run;
    logic [NCH*WIDTH-1:0] out_word;
    logic [NCH-1:0]       wrap;
    logic [NCH-1:0]       done;

    modport master (
        output cfg_wen, cfg_ch, cfg_start, cfg_end, cfg_step, cfg_dwell, cfg_mode,
        output restart, run,
        input  out_word, wrap, done
    );

    modport slave (
        input  cfg_wen, cfg_ch, cfg_start, cfg_end, cfg_step, cfg_dwell, cfg_mode,
        input  restart, run,
        output out_word, wrap, done
    );
endinterface

// File: rtl/dds_sweep_gen.sv
// Multi-channel sawtooth/triangle/one-shot ramp generator feeding DDS tuning words.
// Shadow config is committed to the active set atomically on restart.
//
// dir state | meaning
// DIR_UP    | ramping from start toward end
// DIR_DN    | triangle return leg, ramping from end toward start
module dds_sweep_gen #(
    parameter int WIDTH   = 32,
    parameter int NCH     = 3,
    parameter int DWELL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dds_sweep_gen_if.slave   bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic       DIR_UP      = 1'b0;
    localparam logic       DIR_DN      = 1'b1;
    localparam logic [1:0] MODE_SAW    = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_ONE    = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    typedef struct packed {
        logic [WIDTH-1:0]   start;
        logic [WIDTH-1:0]   stop;
        logic [WIDTH-1:0]   step;
        logic [DWELL_W-1:0] dwell;
        logic [1:0]         mode;
    } cfg_t;

    cfg_t               sh_q   [NCH];
    cfg_t               sh_d   [NCH];
    cfg_t               act_q  [NCH];
    cfg_t               act_d  [NCH];
    logic [WIDTH-1:0]   cur_q  [NCH];
    logic [WIDTH-1:0]   cur_d  [NCH];
    logic [DWELL_W-1:0] cnt_q  [NCH];
    logic [DWELL_W-1:0] cnt_d  [NCH];
    logic [WIDTH:0]     up_sum [NCH];
    logic [WIDTH:0]     dn_lim [NCH];
    logic [NCH-1:0]     dir_q, dir_d;
    logic [NCH-1:0]     wrap_q, wrap_d;
    logic [NCH-1:0]     done_q, done_d;

    // Shadow write; out-of-range channel numbers match no slot and fall through.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sh_d[i] = sh_q[i];
            if (bus.cfg_wen && (bus.cfg_ch == CHW'(i))) begin
                sh_d[i].start = bus.cfg_start;
                sh_d[i].stop  = bus.cfg_end;
                sh_d[i].step  = bus.cfg_step;
                sh_d[i].dwell = bus.cfg_dwell;
                sh_d[i].mode  = bus.cfg_mode;
            end
        end
    end

    // One extra bit so a carry out of cur+step (or start+step) reads as past the boundary.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            up_sum[i] = {1'b0, cur_q[i]} + {1'b0, act_q[i].step};
            dn_lim[i] = {1'b0, act_q[i].start} + {1'b0, act_q[i].step};
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            act_d[i]  = act_q[i];
            cur_d[i]  = cur_q[i];
            cnt_d[i]  = cnt_q[i];
            dir_d[i]  = dir_q[i];
            done_d[i] = done_q[i];
            wrap_d[i] = 1'b0;
            if (bus.restart) begin
                act_d[i]  = sh_d[i];
                cur_d[i]  = sh_d[i].start;
                cnt_d[i]  = '0;
                dir_d[i]  = DIR_UP;
                done_d[i] = 1'b0;
            end else if (bus.run) begin
                if (cnt_q[i] == act_q[i].dwell) begin
                    cnt_d[i] = '0;
                    if ((act_q[i].step == '0) || (act_q[i].mode == MODE_HOLD) ||
                        ((act_q[i].mode == MODE_ONE) && done_q[i])) begin
                        cur_d[i] = cur_q[i];
                    end else if (dir_q[i] == DIR_UP) begin
                        if (up_sum[i] < {1'b0, act_q[i].stop}) begin
                            cur_d[i] = up_sum[i][WIDTH-1:0];
                        end else if (act_q[i].mode == MODE_SAW) begin
                            cur_d[i]  = act_q[i].start;
                            wrap_d[i] = 1'b1;
                        end else if (act_q[i].mode == MODE_TRI) begin
                            cur_d[i] = act_q[i].stop;
                            dir_d[i] = DIR_DN;
                        end else begin
                            cur_d[i]  = act_q[i].stop;
                            done_d[i] = 1'b1;
                        end
                    end else begin
                        if ({1'b0, cur_q[i]} > dn_lim[i]) begin
                            cur_d[i] = cur_q[i] - act_q[i].step;
                        end else begin
                            cur_d[i]  = act_q[i].start;
                            dir_d[i]  = DIR_UP;
                            wrap_d[i] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
                cur_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            dir_q  <= {NCH{DIR_UP}};
            wrap_q <= '0;
            done_q <= '0;
        end else begin
            sh_q   <= sh_d;
            act_q  <= act_d;
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        bus.out_word = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.out_word[i*WIDTH +: WIDTH] = cur_q[i];
        end
    end

    assign bus.wrap = wrap_q;
    assign bus.done = done_q;

endmodule
